// File: rtl/phase1_pkg.sv
// phase1_pkg: shared constants for the phase-1 datapath slice.
//   DATA_W  - datapath / bus width (Z is twice this wide)
//   ALU_*   - 5-bit ALU operation codes
package phase1_pkg;
  localparam int DATA_W = 32;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_MUL  = 5'b00010;
  localparam logic [4:0] ALU_DIV  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00100;
  localparam logic [4:0] ALU_OR   = 5'b00101;
  localparam logic [4:0] ALU_SHR  = 5'b00110;
  localparam logic [4:0] ALU_SHRA = 5'b00111;
  localparam logic [4:0] ALU_SHL  = 5'b01000;
  localparam logic [4:0] ALU_ROR  = 5'b01001;
  localparam logic [4:0] ALU_ROL  = 5'b01010;
  localparam logic [4:0] ALU_NEG  = 5'b01011;
  localparam logic [4:0] ALU_NOT  = 5'b01100;
endpackage

// File: rtl/phase1_alu.sv
// phase1_alu: combinational W x W -> 2W ALU.
//   op     - operation code (phase1_pkg ALU_*)
//   a      - operand A (Y register)
//   b      - operand B (bus)
//   result - {hi, lo}; hi is zero except for mul and div
module phase1_alu
  import phase1_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [4:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] result
);
  localparam int SW = $clog2(W);

  logic [SW-1:0]         shamt;
  logic [2*W-1:0]        dbl;
  logic signed [2*W-1:0] prod;
  logic                  div_zero;
  logic                  div_ovf;
  logic signed [W-1:0]   b_safe;
  logic signed [W-1:0]   quot;
  logic signed [W-1:0]   rem;

  assign shamt = b[SW-1:0];
  assign dbl   = {a, a};
  assign prod  = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});

  // Divide by zero and most-negative / -1 are handled explicitly so the
  // hardware divider never sees an undefined case.
  assign div_zero = (b == '0);
  assign div_ovf  = (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
  assign b_safe   = (div_zero || div_ovf) ? W'(1) : $signed(b);
  assign quot     = $signed(a) / b_safe;
  assign rem      = $signed(a) % b_safe;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = {{W{1'b0}}, a + b};
      ALU_SUB:  result = {{W{1'b0}}, a - b};
      ALU_MUL:  result = prod;
      ALU_DIV: begin
        if (div_zero)     result = {a, {W{1'b1}}};
        else if (div_ovf) result = {{W{1'b0}}, a};
        else              result = {rem, quot};
      end
      ALU_AND:  result = {{W{1'b0}}, a & b};
      ALU_OR:   result = {{W{1'b0}}, a | b};
      ALU_SHR:  result = {{W{1'b0}}, a >> shamt};
      ALU_SHRA: result = {{W{1'b0}}, W'($signed(a) >>> shamt)};
      ALU_SHL:  result = {{W{1'b0}}, a << shamt};
      // Rotates shift a doubled copy of A so the wrapped bits fall into place.
      ALU_ROR:  result = {{W{1'b0}}, W'(dbl >> shamt)};
      ALU_ROL:  result = {{W{1'b0}}, dbl[2*W-1:W] << shamt | dbl[W-1:0] >> (W - int'(shamt))};
      ALU_NEG:  result = {{W{1'b0}}, -b};
      ALU_NOT:  result = {{W{1'b0}}, ~b};
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/phase1_datapath.sv
// phase1_datapath: single-bus datapath slice (R6, R7, PC, IR, MAR, MDR, Y,
// 64-bit Z, HI, LO) driven one micro-step per clock by an external sequencer.
//   Clock, clear           - clock, async active-high reset (zeroes all regs)
//   *in                    - register load enables
//   *out                   - bus source selects (ZHI > ZLO > MDR > PC > R7 > R6)
//   IncrementPC            - with PCin, PC <= PC + 1 instead of bus
//   Read                   - MDR input mux: 1 = Mdatain, 0 = bus
//   ALUControl             - ALU op code, A = Y, B = bus
//   Mdatain                - memory read data
//   *_data_out, big_boy_bus, MDR_data_in - observation outputs
module phase1_datapath
  import phase1_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic               Clock,
  input  logic               clear,
  input  logic               R6in,
  input  logic               R7in,
  input  logic               HIin,
  input  logic               LOin,
  input  logic               MARin,
  input  logic               Zin,
  input  logic               PCin,
  input  logic               MDRin,
  input  logic               IRin,
  input  logic               Yin,
  input  logic               R6out,
  input  logic               R7out,
  input  logic               PCout,
  input  logic               ZHIout,
  input  logic               ZLOout,
  input  logic               MDRout,
  input  logic               IncrementPC,
  input  logic               Read,
  input  logic [4:0]         ALUControl,
  input  logic [WIDTH-1:0]   Mdatain,
  output logic [WIDTH-1:0]   R6_data_out,
  output logic [WIDTH-1:0]   R7_data_out,
  output logic [WIDTH-1:0]   big_boy_bus,
  output logic [WIDTH-1:0]   MDR_data_in,
  output logic [WIDTH-1:0]   MDR_data_out,
  output logic [2*WIDTH-1:0] Z_data_out,
  output logic [WIDTH-1:0]   Y_data_out,
  output logic [WIDTH-1:0]   HI_data_out,
  output logic [WIDTH-1:0]   LO_data_out
);
  logic [WIDTH-1:0]   r6_q, r6_d, r7_q, r7_d, pc_q, pc_d, ir_q, ir_d;
  logic [WIDTH-1:0]   mar_q, mar_d, mdr_q, mdr_d, y_q, y_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0]   bus;
  logic [WIDTH-1:0]   mdr_mux;
  logic [2*WIDTH-1:0] alu_result;
  logic               unused_regs;

  always_comb begin
    if (ZHIout)      bus = z_q[2*WIDTH-1:WIDTH];
    else if (ZLOout) bus = z_q[WIDTH-1:0];
    else if (MDRout) bus = mdr_q;
    else if (PCout)  bus = pc_q;
    else if (R7out)  bus = r7_q;
    else if (R6out)  bus = r6_q;
    else             bus = '0;
  end

  assign mdr_mux = Read ? Mdatain : bus;

  phase1_alu #(.W(WIDTH)) u_alu (
    .op     (ALUControl),
    .a      (y_q),
    .b      (bus),
    .result (alu_result)
  );

  always_comb begin
    r6_d  = R6in  ? bus : r6_q;
    r7_d  = R7in  ? bus : r7_q;
    y_d   = Yin   ? bus : y_q;
    mar_d = MARin ? bus : mar_q;
    ir_d  = IRin  ? bus : ir_q;
    hi_d  = HIin  ? bus : hi_q;
    lo_d  = LOin  ? bus : lo_q;
    mdr_d = MDRin ? mdr_mux : mdr_q;
    z_d   = Zin   ? alu_result : z_q;
    pc_d  = pc_q;
    if (PCin) pc_d = IncrementPC ? pc_q + WIDTH'(1) : bus;
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      r6_q  <= '0;
      r7_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      r6_q  <= r6_d;
      r7_q  <= r7_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // MAR and IR have no consumer until the memory and decode phases exist.
  assign unused_regs = ^{mar_q, ir_q};

  assign R6_data_out  = r6_q;
  assign R7_data_out  = r7_q;
  assign big_boy_bus  = bus;
  assign MDR_data_in  = mdr_mux;
  assign MDR_data_out = mdr_q;
  assign Z_data_out   = z_q;
  assign Y_data_out   = y_q;
  assign HI_data_out  = hi_q;
  assign LO_data_out  = lo_q;
endmodule

// File: tb/tb_phase1_datapath.sv
module tb_phase1_datapath;
  import phase1_pkg::*;

  logic        Clock = 1'b0;
  logic        clear;
  logic        R6in, R7in, HIin, LOin, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic        R6out, R7out, PCout, ZHIout, ZLOout, MDRout;
  logic        IncrementPC, Read;
  logic [4:0]  ALUControl;
  logic [31:0] Mdatain;
  logic [31:0] R6_data_out, R7_data_out, big_boy_bus, MDR_data_in, MDR_data_out;
  logic [63:0] Z_data_out;
  logic [31:0] Y_data_out, HI_data_out, LO_data_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_r6, m_r7, m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo;
  logic [63:0] m_z;

  phase1_datapath dut (
    .Clock(Clock), .clear(clear),
    .R6in(R6in), .R7in(R7in), .HIin(HIin), .LOin(LOin), .MARin(MARin),
    .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .R6out(R6out), .R7out(R7out), .PCout(PCout), .ZHIout(ZHIout),
    .ZLOout(ZLOout), .MDRout(MDRout), .IncrementPC(IncrementPC), .Read(Read),
    .ALUControl(ALUControl), .Mdatain(Mdatain),
    .R6_data_out(R6_data_out), .R7_data_out(R7_data_out),
    .big_boy_bus(big_boy_bus), .MDR_data_in(MDR_data_in),
    .MDR_data_out(MDR_data_out), .Z_data_out(Z_data_out),
    .Y_data_out(Y_data_out), .HI_data_out(HI_data_out), .LO_data_out(LO_data_out)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference ALU from the operation definitions, using wide integer math.
  function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int          sa, sb, s;
    longint      la, lb, q, rm;
    logic [31:0] r;
    sa = a; sb = b; la = sa; lb = sb; s = int'(b[4:0]);
    case (op)
      5'd0:  return {32'h0, a + b};
      5'd1:  return {32'h0, a - b};
      5'd2:  return la * lb;
      5'd3: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        q = la / lb; rm = la % lb;
        return {rm[31:0], q[31:0]};
      end
      5'd4:  return {32'h0, a & b};
      5'd5:  return {32'h0, a | b};
      5'd6:  return {32'h0, a >> s};
      5'd7:  begin r = sa >>> s; return {32'h0, r}; end
      5'd8:  return {32'h0, a << s};
      5'd9:  begin r = a; for (int i = 0; i < s; i++) r = {r[0], r[31:1]}; return {32'h0, r}; end
      5'd10: begin r = a; for (int i = 0; i < s; i++) r = {r[30:0], r[31]}; return {32'h0, r}; end
      5'd11: return {32'h0, 32'h0 - b};
      5'd12: return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {R6in, R7in, HIin, LOin, MARin, Zin, PCin, MDRin, IRin, Yin} = '0;
    {R6out, R7out, PCout, ZHIout, ZLOout, MDRout} = '0;
    IncrementPC = 0; Read = 0; ALUControl = 5'd0; Mdatain = 32'h0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic model_reset();
    {m_r6, m_r7, m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo} = '0;
    m_z = '0;
  endtask

  task automatic mem_to_mdr(input logic [31:0] v);
    Read = 1; MDRin = 1; Mdatain = v; tick(); m_mdr = v;
  endtask

  task automatic set_r6(input logic [31:0] v);
    mem_to_mdr(v); MDRout = 1; R6in = 1; tick(); m_r6 = m_mdr;
  endtask

  task automatic set_r7(input logic [31:0] v);
    mem_to_mdr(v); MDRout = 1; R7in = 1; tick(); m_r7 = m_mdr;
  endtask

  task automatic y_from_r6();
    R6out = 1; Yin = 1; tick(); m_y = m_r6;
  endtask

  task automatic alu_r7(input logic [4:0] op);
    R7out = 1; Zin = 1; ALUControl = op; tick(); m_z = alu_ref(op, m_y, m_r7);
  endtask

  task automatic z_to_lohi();
    ZLOout = 1; LOin = 1; tick(); m_lo = m_z[31:0];
    ZHIout = 1; HIin = 1; tick(); m_hi = m_z[63:32];
  endtask

  task automatic read_pc(input string tag);
    PCout = 1; #1; check(tag, {32'h0, big_boy_bus}, {32'h0, m_pc}); idle();
  endtask

  task automatic sel_from(input int k);
    ZHIout = (k <= 0); ZLOout = (k <= 1); MDRout = (k <= 2);
    PCout = (k <= 3); R7out = (k <= 4); R6out = (k <= 5);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_r6"}, {32'h0, R6_data_out}, 64'h0);
    check({tag, "_r7"}, {32'h0, R7_data_out}, 64'h0);
    check({tag, "_mdr"}, {32'h0, MDR_data_out}, 64'h0);
    check({tag, "_z"}, Z_data_out, 64'h0);
    check({tag, "_y"}, {32'h0, Y_data_out}, 64'h0);
    check({tag, "_hi"}, {32'h0, HI_data_out}, 64'h0);
    check({tag, "_lo"}, {32'h0, LO_data_out}, 64'h0);
    check({tag, "_mar"}, {32'h0, dut.mar_q}, 64'h0);
    check({tag, "_ir"}, {32'h0, dut.ir_q}, 64'h0);
    check({tag, "_bus"}, {32'h0, big_boy_bus}, 64'h0);
  endtask

  logic [31:0] src [6];
  logic [31:0] old_zlo;
  logic [31:0] ra, rb;
  logic [4:0]  rop;

  initial begin
    idle();
    clear = 1;
    model_reset();
    #3;
    check_all_zero("reset");
    #9 clear = 0;

    // Divide 8 / 3
    set_r6(32'd8); set_r7(32'd3); y_from_r6(); alu_r7(ALU_DIV);
    check("div_8_3_z", Z_data_out, 64'h00000002_00000002);
    z_to_lohi();
    check("div_8_3_lo", {32'h0, LO_data_out}, 64'h2);
    check("div_8_3_hi", {32'h0, HI_data_out}, 64'h2);

    // Multiply -2 * 3
    set_r6(32'hFFFFFFFE); y_from_r6(); set_r7(32'd3); alu_r7(ALU_MUL);
    check("mul_neg", Z_data_out, 64'hFFFFFFFF_FFFFFFFA);

    // Divide boundaries
    set_r6(32'hFFFFFFF9); y_from_r6(); set_r7(32'd2); alu_r7(ALU_DIV);
    check("div_m7_2", Z_data_out, 64'hFFFFFFFF_FFFFFFFD);
    set_r6(32'd5); y_from_r6(); set_r7(32'd0); alu_r7(ALU_DIV);
    check("div_5_0", Z_data_out, 64'h00000005_FFFFFFFF);

    // Bus idle value and MDR mux from the bus
    #1;
    check("bus_none", {32'h0, big_boy_bus}, 64'h0);
    R6out = 1; Read = 0; MDRin = 1; #1;
    check("mdr_in_bus", {32'h0, MDR_data_in}, {32'h0, m_r6});
    tick(); m_mdr = m_r6;
    check("mdr_from_bus", {32'h0, MDR_data_out}, {32'h0, m_mdr});

    // Bus priority with distinct values in every source
    set_r6(32'hFFFFFFF5); set_r7(32'd22); y_from_r6(); alu_r7(ALU_MUL);
    mem_to_mdr(32'd44); MDRout = 1; PCin = 1; tick(); m_pc = m_mdr;
    mem_to_mdr(32'd33);
    src[0] = m_z[63:32]; src[1] = m_z[31:0]; src[2] = m_mdr;
    src[3] = m_pc; src[4] = m_r7; src[5] = m_r6;
    for (int k = 0; k < 6; k++) begin
      sel_from(k); #1;
      check($sformatf("prio_%0d", k), {32'h0, big_boy_bus}, {32'h0, src[k]});
    end
    idle();

    // Same register driven and loaded in one step
    PCout = 1; PCin = 1; IncrementPC = 1; #1;
    check("pc_drive_old", {32'h0, big_boy_bus}, {32'h0, m_pc});
    tick(); m_pc = m_pc + 32'd1;
    read_pc("pc_incr");
    old_zlo = m_z[31:0];
    ZLOout = 1; Zin = 1; ALUControl = ALU_ADD; #1;
    check("zlo_drive_old", {32'h0, big_boy_bus}, {32'h0, old_zlo});
    tick(); m_z = alu_ref(ALU_ADD, m_y, old_zlo);
    check("z_self_load", Z_data_out, m_z);

    // PC wrap
    mem_to_mdr(32'hFFFFFFFF); MDRout = 1; PCin = 1; tick(); m_pc = m_mdr;
    read_pc("pc_max");
    PCin = 1; IncrementPC = 1; tick(); m_pc = m_pc + 32'd1;
    read_pc("pc_wrap");

    // Mid-sequence asynchronous clear
    set_r6(32'h12345678); y_from_r6(); set_r7(32'h9); alu_r7(ALU_OR); z_to_lohi();
    R6out = 1;
    #3 clear = 1;
    #1 check_all_zero("midclr");
    #1 clear = 0;
    model_reset();
    idle();

    // Fetch from the zero state
    PCout = 1; MARin = 1; Zin = 1; ALUControl = ALU_ADD; tick();
    m_mar = m_pc; m_z = alu_ref(ALU_ADD, m_y, m_pc);
    ZLOout = 1; PCin = 1; IncrementPC = 1; Read = 1; MDRin = 1; Mdatain = 32'h28918000; tick();
    m_pc = m_pc + 32'd1; m_mdr = 32'h28918000;
    MDRout = 1; IRin = 1; tick(); m_ir = m_mdr;
    check("fetch_mar", {32'h0, dut.mar_q}, {32'h0, m_mar});
    read_pc("fetch_pc");
    check("fetch_mdr", {32'h0, MDR_data_out}, 64'h28918000);
    check("fetch_ir", {32'h0, dut.ir_q}, {32'h0, m_ir});

    // Randomized ALU operations through the full Y / Z / HI / LO path
    for (int n = 0; n < 60; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'h0;
        2: rb = $urandom_range(0, 40);
        default: rb = 32'hFFFFFFFF;
      endcase
      rop = 5'($urandom_range(0, 15));
      set_r6(ra); set_r7(rb); y_from_r6(); alu_r7(rop);
      check($sformatf("rnd%0d_op%0d_z", n, rop), Z_data_out, m_z);
      z_to_lohi();
      check($sformatf("rnd%0d_lo", n), {32'h0, LO_data_out}, {32'h0, m_lo});
      check($sformatf("rnd%0d_hi", n), {32'h0, HI_data_out}, {32'h0, m_hi});
    end

    check("final_r6", {32'h0, R6_data_out}, {32'h0, m_r6});
    check("final_r7", {32'h0, R7_data_out}, {32'h0, m_r7});
    check("final_y", {32'h0, Y_data_out}, {32'h0, m_y});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/phase1_datapath.md
Name: phase1_datapath

Overview:
Phase-1 single-bus CPU datapath slice with register R6, R7, PC, IR, MAR, MDR, Y, Z (64-bit), HI and LO on one shared 32-bit bus, plus a 5-bit-coded ALU. All control strobes come from an external sequencer or bench, one micro-step per clock. Later phases grow it into the full CPU.

Parameters:
WIDTH, 32, datapath/bus width (Z is 2*WIDTH)

Ports:
Clock  in  1  system clock, all registers load on rising edge
clear  in  1  asynchronous active-high reset, zeroes every register
R6in, R7in, HIin, LOin, MARin, Zin, PCin, MDRin, IRin, Yin  in  1 each  register load enables, sampled at posedge
R6out, R7out, PCout, ZHIout, ZLOout, MDRout  in  1 each  bus source selects
IncrementPC  in  1  with PCin: PC <= PC+1 instead of bus
Read  in  1  MDR input mux: 1 = Mdatain, 0 = bus
ALUControl  in  5  ALU operation code
Mdatain  in  32  memory read data
R6_data_out, R7_data_out  out  32  register contents
big_boy_bus  out  32  current bus value
MDR_data_in  out  32  MDR input mux output
MDR_data_out  out  32  MDR contents
Z_data_out  out  64  Z contents {hi,lo}
Y_data_out, HI_data_out, LO_data_out  out  32  register contents

Behaviour:
- clear high, at any time and asynchronously: all registers = 0, so every output register value is 0; the bus then reads 0 unless a source is selected.
- Bus is combinational. Source priority when several selects are high: ZHIout > ZLOout > MDRout > PCout > R7out > R6out. No select high: bus = 0.
- Register X loads on posedge when Xin = 1, otherwise holds. All loads take 1 cycle.
- R6, R7, Y, MAR, IR, HI, LO load from the bus.
- MDR loads MDR_data_in when MDRin = 1. MDR_data_in = Read ? Mdatain : bus.
- PC: PCin & IncrementPC loads PC+1, wrapping 0xFFFFFFFF to 0. PCin alone loads the bus.
- ALU is combinational. A = Y, B = bus. Z loads the 64-bit result on posedge when Zin = 1. ZLOout drives Z[31:0]; ZHIout drives Z[63:32].
- ALU codes. Unless noted, result = {32'h0, r32}.
  - 00000 add A+B, wraps.
  - 00001 sub A-B.
  - 00010 mul: signed 64-bit product A*B.
  - 00011 div: signed. Z[31:0] = quotient, truncated toward zero. Z[63:32] = remainder, sign of dividend A. Divide by zero: quotient = 0xFFFFFFFF, remainder = A.
  - 00100 and. 00101 or.
  - 00110 shr: logical, by B[4:0].
  - 00111 shra: arithmetic, by B[4:0].
  - 01000 shl, by B[4:0].
  - 01001 ror, by B[4:0]. 01010 rol, by B[4:0].
  - 01011 neg: -B. 01100 not: ~B.
  - Any other code: Z result = 0.
- Simultaneous load and drive of the same register: the old value is driven that cycle and the new value is visible after the edge.

Decomposition:
- Shared package phase1_pkg: WIDTH constant and the ALU opcode localparams listed above.
- One natural sub-module: phase1_alu, the combinational 32x32 to 64-bit ALU.
- Registers and the bus mux stay inline.

Test Plan:
- Divide: MDR←8 then R6←MDR, MDR←3 then R7←MDR. R6out+Yin; R7out+Zin with ALUControl=00011; ZLOout+LOin; ZHIout+HIin. Required: Z = 0x00000002_00000002, LO = 2, HI = 2.
- Fetch: PC = 0. PCout+MARin+Zin, then ZLOout+PCin+IncrementPC+Read+MDRin with Mdatain = 0x28918000, then MDRout+IRin. Required: MAR = 0, PC = 1, MDR = IR = 0x28918000.
- Multiply: Y = 0xFFFFFFFE, bus = 3, code 00010. Required: Z = 0xFFFFFFFF_FFFFFFFA.
- Divide boundaries: -7/2 gives Z = 0xFFFFFFFF_FFFFFFFD (remainder -1, quotient -3). 5/0 gives Z = 0x00000005_FFFFFFFF.
- Bus and MDR mux: no selects high gives bus = 0. Read = 0 with R6out gives MDR_data_in = R6.
- Reset: assert clear mid-sequence between edges. All registers read 0 immediately; after release, operation resumes from the zero state.
